// File: rtl/ex_result_stage.sv
// ex_result_stage: execute-to-memory boundary register.
// Selects the execute result (ALU, comparator, PC+4 or zero), registers it
// with its destination index and write enable, and hands it to the memory
// stage over valid/ready. Flush discards everything held and incoming.
// Optional feature macro: EX_RESULT_SKID_EN adds a skid entry and a
// registered in_ready (no combinational path from out_ready).
module ex_result_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_sel,
  input  logic [31:0] in_alu,
  input  logic [31:0] in_comp,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_rd,
  input  logic        in_we,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_we,
  output logic [1:0]  occupancy
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] main_data_q, main_data_d;
  logic [4:0]  main_rd_q, main_rd_d;
  logic        main_we_q, main_we_d;

  logic [31:0] new_data;
  logic        new_we;
  logic        accept;
  logic        out_fire;

  // Result mux for the incoming instruction; x0 and sel=11 never write.
  always_comb begin
    new_data = '0;
    case (in_sel)
      2'b00:   new_data = in_alu;
      2'b01:   new_data = in_comp;
      2'b10:   new_data = in_pc + 32'd4;
      default: new_data = '0;
    endcase
    new_we = in_we && (in_rd != 5'd0) && (in_sel != 2'b11);
  end

  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q != S_EMPTY);
  assign out_fire  = out_valid && out_ready;
  assign out_data  = main_data_q;
  assign out_rd    = main_rd_q;
  assign out_we    = main_we_q;
  assign occupancy = (state_q == S_TWO) ? 2'd2 :
                     (state_q == S_ONE) ? 2'd1 : 2'd0;

`ifdef EX_RESULT_SKID_EN
  logic [31:0] skid_data_q, skid_data_d;
  logic [4:0]  skid_rd_q, skid_rd_d;
  logic        skid_we_q, skid_we_d;
  logic        in_ready_q, in_ready_d;

  assign in_ready = in_ready_q;

  // Next-state for main/skid entries; flush overrides every other event.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_rd_d   = main_rd_q;
    main_we_d   = main_we_q;
    skid_data_d = skid_data_q;
    skid_rd_d   = skid_rd_q;
    skid_we_d   = skid_we_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: if (accept) begin
          state_d     = S_ONE;
          main_data_d = new_data;
          main_rd_d   = in_rd;
          main_we_d   = new_we;
        end
        S_ONE: begin
          if (out_fire && accept) begin
            main_data_d = new_data;
            main_rd_d   = in_rd;
            main_we_d   = new_we;
          end else if (out_fire) begin
            state_d = S_EMPTY;
          end else if (accept) begin
            state_d     = S_TWO;
            skid_data_d = new_data;
            skid_rd_d   = in_rd;
            skid_we_d   = new_we;
          end
        end
        S_TWO: if (out_fire) begin
          state_d     = S_ONE;
          main_data_d = skid_data_q;
          main_rd_d   = skid_rd_q;
          main_we_d   = skid_we_q;
        end
        default: state_d = S_EMPTY;
      endcase
    end
    // Registered ready: low exactly while both entries are occupied.
    in_ready_d = (state_d != S_TWO);
  end

  // State and storage registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      main_data_q <= '0;
      main_rd_q   <= '0;
      main_we_q   <= 1'b0;
      skid_data_q <= RESET_PC;
      skid_rd_q   <= '0;
      skid_we_q   <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_rd_q   <= main_rd_d;
      main_we_q   <= main_we_d;
      skid_data_q <= skid_data_d;
      skid_rd_q   <= skid_rd_d;
      skid_we_q   <= skid_we_d;
      in_ready_q  <= in_ready_d;
    end
  end
`else
  // Single-entry build holds no PC-derived state besides the main entry.
  logic unused_reset_pc;
  assign unused_reset_pc = ^RESET_PC;

  assign in_ready = !out_valid || out_ready;

  // Next-state for the single entry; flush overrides every other event.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_rd_d   = main_rd_q;
    main_we_d   = main_we_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else if (accept) begin
      state_d     = S_ONE;
      main_data_d = new_data;
      main_rd_d   = in_rd;
      main_we_d   = new_we;
    end else if (out_fire) begin
      state_d = S_EMPTY;
    end
  end

  // State and storage registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      main_data_q <= '0;
      main_rd_q   <= '0;
      main_we_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_rd_q   <= main_rd_d;
      main_we_q   <= main_we_d;
    end
  end
`endif

endmodule
